// File: rtl/control_read_pipe_if.sv
// Bundle of the fetch, execute and writeback handshakes around control_read_pipe.
// master = surrounding pipeline, slave = the read-stage controller.
interface control_read_pipe_if #(
  parameter int INSTR_W    = 8,
  parameter int REG_ADDR_W = 2
);
  logic                  in_valid;
  logic [INSTR_W-1:0]    instr;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic                  ir2_load;
  logic                  r1r2_load;
  logic                  r1_sel;
  logic                  stall;
  logic                  halted;

  modport master (
    output in_valid, instr, out_ready, wb_valid, wb_addr,
    input  in_ready, out_valid, ir2_load, r1r2_load, r1_sel, stall, halted
  );

  modport slave (
    input  in_valid, instr, out_ready, wb_valid, wb_addr,
    output in_ready, out_valid, ir2_load, r1r2_load, r1_sel, stall, halted
  );
endinterface

// File: rtl/control_read_pipe.sv
// Read-stage controller: decodes register use, scoreboards pending writes, issues to execute.
// Optional macro CONTROL_READ_WB_BYPASS_EN lets a same-cycle writeback clear hide the hazard.
module control_read_pipe #(
  parameter int INSTR_W    = 8,
  parameter int REG_ADDR_W = 2,
  parameter int ORI_REG    = 1
) (
  input logic                clock,
  input logic                reset,
  control_read_pipe_if.slave bus
);
  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] ORI_ADDR = REG_ADDR_W'(ORI_REG);

  typedef enum logic {RUN, HALT} state_t;

  state_t                state, state_next;
  logic [NUM_REGS-1:0]   pending, pending_next, pending_eff;
  logic                  out_valid_q, out_valid_next;

  logic [3:0]            opcode;
  logic [REG_ADDR_W-1:0] r1_addr, r2_addr, dest_addr;
  logic is_shift, is_ori, is_add, is_sub, is_nand, is_load, is_store, is_stop;
  logic reads_r1, reads_r2, writes_r1, has_dest, reads_any, hazard;
  logic can_accept, issue;

  assign opcode  = bus.instr[3:0];
  assign r1_addr = REG_ADDR_W'(bus.instr[7:6]);
  assign r2_addr = REG_ADDR_W'(bus.instr[5:4]);

  // shift and ori match on the low three bits; unlisted opcodes fall through as nop
  assign is_shift = (opcode[2:0] == 3'd3);
  assign is_ori   = (opcode[2:0] == 3'd7);
  assign is_load  = (opcode == 4'd0);
  assign is_stop  = (opcode == 4'd1);
  assign is_store = (opcode == 4'd2);
  assign is_add   = (opcode == 4'd4);
  assign is_sub   = (opcode == 4'd6);
  assign is_nand  = (opcode == 4'd8);

  assign reads_r2  = is_add | is_sub | is_nand | is_load | is_store;
  assign reads_r1  = reads_r2 | is_shift;
  assign writes_r1 = is_add | is_sub | is_nand | is_shift | is_load;
  assign has_dest  = writes_r1 | is_ori;
  assign dest_addr = is_ori ? ORI_ADDR : r1_addr;
  assign reads_any = reads_r1 | is_ori;

`ifdef CONTROL_READ_WB_BYPASS_EN
  always_comb begin
    pending_eff = pending;
    if (bus.wb_valid) pending_eff[bus.wb_addr] = 1'b0;
  end
`else
  assign pending_eff = pending;
`endif

  assign hazard = (reads_r1 & pending_eff[r1_addr])
                | (reads_r2 & pending_eff[r2_addr])
                | (is_ori   & pending_eff[ORI_ADDR])
                | (has_dest & pending_eff[dest_addr]);

  always_comb begin
    state_next     = state;
    pending_next   = pending;
    out_valid_next = out_valid_q;
    can_accept     = 1'b0;
    issue          = 1'b0;
    bus.in_ready   = 1'b0;
    bus.stall      = 1'b0;
    bus.ir2_load   = 1'b0;
    bus.r1r2_load  = 1'b0;
    bus.r1_sel     = 1'b0;

    can_accept    = !reset && !hazard && (state == RUN) && (bus.out_ready || !out_valid_q);
    issue         = bus.in_valid && can_accept;
    bus.in_ready  = can_accept;
    bus.stall     = !reset && bus.in_valid && hazard && (state == RUN);
    bus.ir2_load  = issue && !is_stop;
    bus.r1r2_load = issue && reads_any;
    bus.r1_sel    = issue && is_ori;

    if (issue && is_stop) state_next = HALT;

    if (bus.ir2_load) out_valid_next = 1'b1;
    else if (bus.out_ready && out_valid_q) out_valid_next = 1'b0;

    // clear first so that a same-entry set in this cycle wins
    if (bus.wb_valid) pending_next[bus.wb_addr] = 1'b0;
    if (issue && has_dest) pending_next[dest_addr] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      pending     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      pending     <= pending_next;
      out_valid_q <= out_valid_next;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.halted    = (state == HALT);
endmodule

// File: doc/control_read_pipe.md
CONTROL_READ_PIPE -- requirements
Module: control_read_pipe

Interface
REQ-001 SHALL have parameter INSTR_W, default 8, meaning instruction width (min 8); R1 field instr[7:6], R2 field instr[5:4], opcode instr[3:0].
REQ-002 SHALL have parameter REG_ADDR_W, default 2, meaning register index width; NUM_REGS = 2**REG_ADDR_W scoreboard entries.
REQ-003 SHALL have parameter ORI_REG, default 1, meaning implicit register (k1) read and written by ori.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports in_valid input 1 and instr input INSTR_W, meaning fetch offers an instruction.
REQ-007 SHALL have port in_ready  output  1  read stage accepts this cycle.
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1, meaning execute-stage handshake for IR2/R1/R2.
REQ-009 SHALL have ports wb_valid input 1 and wb_addr input REG_ADDR_W, meaning writeback retires the pending write to wb_addr.
REQ-010 SHALL have ports ir2_load, r1r2_load, r1_sel (output 1 each), meaning IR2 load, R1/R2 load, R1 source select (1 = ORI_REG).
REQ-011 SHALL have ports stall output 1 (hazard blocks a valid instruction) and halted output 1 (stop retired).

Function
REQ-012 SHALL decode: shift = opcode[2:0]==3; ori = opcode[2:0]==7; add 4, sub 6, nand 8, load 0, store 2, nop 10, stop 1; any other opcode SHALL be treated as nop.
REQ-013 SHALL use sources: add/sub/nand/load/store read R1,R2; shift reads R1; ori reads ORI_REG; nop/stop read none.
REQ-014 SHALL use destinations: add/sub/nand/shift/load write R1; ori writes ORI_REG; store/nop/stop write none.
REQ-015 SHALL assert hazard when any source or the destination has its pending bit set (RAW and WAW).
REQ-016 SHALL compute issue = in_valid & ~hazard & ~halted & (out_ready | ~out_valid); in_ready = ~hazard & ~halted & (out_ready | ~out_valid), combinational.
REQ-017 SHALL drive ir2_load = issue & ~stop; r1r2_load = issue & op reads any register; r1_sel = issue & ori; all three 0 when no issue.
REQ-018 SHALL set out_valid next cycle on issue of non-stop; SHALL clear out_valid when out_ready & out_valid & no issue; out_valid SHALL hold while out_ready low.
REQ-019 SHALL set pending[dest] on issue of an op with a destination; SHALL clear pending[wb_addr] on wb_valid; same-cycle set and clear of one entry: set wins.
REQ-020 SHALL drive stall = in_valid & hazard & ~halted.
REQ-021 SHALL implement states RUN and HALT: RUN->HALT on issue of stop; HALT held until reset; in HALT in_ready=0 and no load enables asserted; out_valid still drains; wb still clears pending.
REQ-022 SHALL accept at most one instruction per cycle; back-to-back issue SHALL be sustained when out_ready=1 and no hazard.

Reset
REQ-023 SHALL, on reset high at a rising edge, clear out_valid, halted, state to RUN and all pending bits, regardless of in-flight activity.
REQ-024 SHALL, while reset is high, force in_ready, ir2_load, r1r2_load, r1_sel and stall to 0.

Configuration
REQ-025 SHALL support macro CONTROL_READ_WB_BYPASS_EN: when defined, a register whose pending bit clears via wb_valid/wb_addr in the current cycle SHALL be treated as not pending for hazard evaluation in that same cycle; when undefined, the clear takes effect only from the next cycle (one extra stall cycle).

Verification
REQ-026 SHALL test: reset, then add R1=1,R2=2 (instr 8'h64) with out_ready=1 -> ir2_load=1, r1r2_load=1, r1_sel=0 same cycle; out_valid=1 next cycle; pending[1]=1.
REQ-027 SHALL test: add writing R1=1, then ori (instr 8'h07) with no wb -> stall=1, in_ready=0 every cycle; wb_valid=1, wb_addr=1 -> ori issues same cycle with bypass macro, next cycle without; r1_sel=1 on issue.
REQ-028 SHALL test: out_ready=0 with out_valid=1, in_valid=1 nop -> in_ready=0, out_valid held; out_ready=1 -> nop issues that cycle, out_valid stays 1.
REQ-029 SHALL test: stop (instr 8'h01) -> ir2_load=0, halted=1 next cycle; following add with in_valid=1 -> in_ready=0, stall=0, no load enables; reset -> halted=0.
REQ-030 SHALL test: issue load writing R3 and wb_valid=1, wb_addr=3 in same cycle -> pending[3]=1 after edge; reset mid-stall -> pending all 0, out_valid=0 next cycle.
REQ-031 SHALL test: opcode 4'hE with in_valid=1 -> treated as nop: ir2_load=1, r1r2_load=0, no pending bit set.
